baud_gen: RTL and testbench

- Consumer end of the divisor/update/AK handshake driven by the switch reader in the SPART miniproject.
- Accepts a new 16-bit baud divisor through a 4-phase level handshake and acknowledges it.
- Generates the 16x oversample enable (rx_tick) and the 1x bit enable (tx_tick) for the SPART receive and transmit datapaths.

---
 rtl/baud_gen.sv | 149 ++++++++++++++
 tb/tb_baud_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen.sv
// baud_gen -- baud-rate enable generator for the SPART receive/transmit paths.
//
// Accepts a 16-bit divisor from the switch reader over a 4-phase level
// handshake (update/AK), then produces:
//   rx_tick : one-cycle pulse every div_reg clocks (16x oversample enable)
//   tx_tick : one-cycle pulse on every OVERSAMPLE-th rx_tick (1x bit enable)
//
// Ports:
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   divisor     in  16   proposed divisor, valid while update is high
//   update      in   1   load request, held high until AK is seen high
//   AK          out  1   registered acknowledge
//   rx_tick     out  1   oversample enable pulse
//   tx_tick     out  1   bit enable pulse
//   div_clamped out  1   last loaded divisor was raised to MIN_DIV
//
// Optional feature (compile-time macro BAUD_DIV_GUARD_EN):
//   defined   -> divisors below MIN_DIV are loaded as MIN_DIV and flagged
//                on div_clamped
//   undefined -> divisors load unchanged (0 gives a 65536-cycle period) and
//                div_clamped is tied low
module baud_gen #(
  parameter logic [15:0] DEFAULT_DIV = 16'd326,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter logic [15:0] MIN_DIV     = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] divisor,
  input  logic        update,
  output logic        AK,
  output logic        rx_tick,
  output logic        tx_tick,
  output logic        div_clamped
);

  localparam int unsigned PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);

  // Handshake states; AK is the state register itself.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  generate
    if (OVERSAMPLE < 2 || OVERSAMPLE > 256 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
      $error("baud_gen: OVERSAMPLE must be a power of two in 2..256");
    end
    if (MIN_DIV == 16'd0) begin : g_bad_min
      $error("baud_gen: MIN_DIV must be at least 1");
    end
  endgenerate

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [15:0]   div_reg;
  logic [15:0]   cnt;
  logic [PW-1:0] phase;
  logic          load;
  logic [15:0]   load_div;
  logic          load_clamp;
  logic          cnt_zero;

  // Divisor actually loaded on a handshake edge.
`ifdef BAUD_DIV_GUARD_EN
  always_comb begin
    load_clamp = (divisor < MIN_DIV);
    load_div   = load_clamp ? MIN_DIV : divisor;
  end
`else
  always_comb begin
    load_clamp = 1'b0;
    load_div   = divisor;
  end
`endif

  // Only the IDLE state accepts a divisor, so a divisor change while AK is
  // high never reloads, and an update raised in the cycle AK falls is taken
  // on the next edge, once the FSM is back in IDLE.
  assign load = (state == IDLE) && update;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (update)  state_nxt = ACK;
      ACK:     if (!update) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign AK = state[0];

  assign cnt_zero = (cnt == '0);

  // Divisor register, down counter and phase counter. A load edge takes
  // priority over the normal reload/increment so the new period starts
  // cleanly from the load edge, even when a tick is being output in the
  // same cycle. cnt wraps mod 2^16, so divisor 0 reloads to 16'hFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= DEFAULT_DIV;
      cnt     <= DEFAULT_DIV - 16'd1;
      phase   <= '0;
    end else if (load) begin
      div_reg <= load_div;
      cnt     <= load_div - 16'd1;
      phase   <= '0;
    end else begin
      if (cnt_zero) begin
        cnt <= div_reg - 16'd1;
        if (phase == PHASE_LAST) begin
          phase <= '0;
        end else begin
          phase <= phase + 1'b1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // Clamp flag changes only on load edges.
`ifdef BAUD_DIV_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_clamped <= 1'b0;
    end else if (load) begin
      div_clamped <= load_clamp;
    end
  end
`else
  assign div_clamped = 1'b0;
`endif

  // Ticks are decoded from registers and gated by rst_n so they are low for
  // the whole time reset is asserted.
  assign rx_tick = cnt_zero && rst_n;
  assign tx_tick = rx_tick && (phase == PHASE_LAST);

endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen -- scoreboard bench for baud_gen.
// A reference model tracks the number of cycles since the last load (or
// reset release) and the active period, derives the expected rx_tick,
// tx_tick, AK and div_clamped per cycle with modular arithmetic, and queues
// them; a separate monitor pops and compares on every falling clock edge.
module tb_baud_gen;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] divisor = 16'd0;
  logic        update = 1'b0;
  logic        AK;
  logic        rx_tick;
  logic        tx_tick;
  logic        div_clamped;

  baud_gen #(
    .DEFAULT_DIV(16'd326),
    .OVERSAMPLE (OS),
    .MIN_DIV    (16'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .divisor    (divisor),
    .update     (update),
    .AK         (AK),
    .rx_tick    (rx_tick),
    .tx_tick    (tx_tick),
    .div_clamped(div_clamped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rx;
    logic tx;
    logic ak;
    logic clamped;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Reference model state: m_k is the 1-based cycle index since the last
  // load edge (cycle 1 is the cycle after the load edge).
  int m_k = 1;
  int m_per = 326;
  bit m_ak = 1'b0;
  bit m_clamp = 1'b0;

  task automatic model_reset();
    m_k = 1;
    m_per = 326;
    m_ak = 1'b0;
    m_clamp = 1'b0;
  endtask

  task automatic model_edge(input logic u, input logic [15:0] d);
    if (!m_ak && u) begin
      m_ak = 1'b1;
      m_k = 1;
`ifdef BAUD_DIV_GUARD_EN
      if (d < 16'd2) begin
        m_per = 2;
        m_clamp = 1'b1;
      end else begin
        m_per = int'(d);
        m_clamp = 1'b0;
      end
`else
      m_per = (d == 16'd0) ? 65536 : int'(d);
      m_clamp = 1'b0;
`endif
    end else begin
      m_k++;
      if (m_ak && !u) m_ak = 1'b0;
    end
  endtask

  // Model process: capture inputs at the edge, update after the driver has
  // applied this cycle's changes, then queue the expected outputs.
  initial begin
    logic u_e, r_e;
    logic [15:0] d_e;
    exp_t e;
    forever begin
      @(posedge clk);
      u_e = update;
      d_e = divisor;
      r_e = rst_n;
      #3;
      if (r_e) model_edge(u_e, d_e);
      if (!rst_n) model_reset();
      e.rx = rst_n && (m_k % m_per == 0);
      e.tx = e.rx && (m_k % (m_per * OS) == 0);
      e.ak = m_ak && rst_n;
      e.clamped = m_clamp;
      q.push_back(e);
    end
  end

  task automatic compare(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, req);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("rx_tick", rx_tick, e.rx);
        compare("tx_tick", tx_tick, e.tx);
        compare("AK", AK, e.ak);
        compare("div_clamped", div_clamped, e.clamped);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic handshake(input logic [15:0] d, input int hold);
    divisor = d;
    update = 1'b1;
    cyc(hold);
    update = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(700);

    handshake(16'd4, 5);
    cyc(80);

    // Divisor change while AK is high must not reload.
    divisor = 16'd4;
    update = 1'b1;
    cyc(2);
    divisor = 16'd9;
    cyc(3);
    update = 1'b0;
    cyc(80);

    handshake(16'd1, 2);
    cyc(40);

    handshake(16'd0, 2);
    cyc(65540);

    handshake(16'd8, 2);
    cyc(200);

    // Randomised handshakes, mid-ACK divisor changes, back-to-back updates.
    for (int i = 0; i < 40; i++) begin
      int hold;
      int gap;
      hold = int'($urandom_range(1, 4));
      gap = int'($urandom_range(0, 60));
      divisor = 16'($urandom_range(1, 24));
      update = 1'b1;
      cyc(hold);
      if ($urandom_range(0, 1) == 1) begin
        divisor = 16'($urandom);
        cyc(1);
      end
      update = 1'b0;
      cyc(1 + gap);
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        cyc(int'($urandom_range(1, 3)));
        rst_n = 1'b1;
        cyc(int'($urandom_range(0, 20)));
      end
    end

    // Reset in the middle of a handshake.
    divisor = 16'd4;
    update = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    update = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(700);

    @(negedge clk);
    #1;
    if (vectors == 0) begin
      miscompares++;
      $display("FAIL scoreboard: got 0 vectors expected >0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
